// File: rtl/jk_counter_updown_if.sv
// Control and status bundle for one jk_counter_updown stage.
// The counter is the slave; whatever drives enable/load/updown is the master.
interface jk_counter_updown_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic             updown;
  logic [WIDTH-1:0] loaddata;
  logic [WIDTH-1:0] count;
  logic             terminal;
  logic             carryout;
  logic             wrapped;

  modport master (
    output enable, load, updown, loaddata,
    input  count, terminal, carryout, wrapped
  );

  modport slave (
    input  enable, load, updown, loaddata,
    output count, terminal, carryout, wrapped
  );
endinterface

// File: rtl/jk_counter_updown.sv
// Mod-MODULUS synchronous up/down counter built from per-bit JK toggle stages,
// with parallel load, cascade carry and a sticky wrap flag.
module jk_counter_updown #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic                 clockpulse,
  input logic                 clear,
  jk_counter_updown_if.slave  bus
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] force_value;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic             at_end;
  logic             step;
  logic             wrap;

  // Out-of-range load data collapses to 0 so count never leaves 0..MODULUS-1.
  assign load_value  = ({1'b0, bus.loaddata} < MOD_EXT) ? bus.loaddata : '0;
  assign at_end      = bus.updown ? (count_reg == LAST) : (count_reg == '0);
  assign step        = bus.enable & ~bus.load;
  assign wrap        = at_end & step;
  assign force_value = bus.updown ? '0 : LAST;

  assign ones_below[0]  = 1'b1;
  assign zeros_below[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign ones_below[gi]  = ones_below[gi-1]  &  count_reg[gi-1];
      assign zeros_below[gi] = zeros_below[gi-1] & ~count_reg[gi-1];
    end

    // Load and wrap both force a target value through J/K; otherwise J=K=toggle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
      assign toggle[gi] = bus.enable & (bus.updown ? ones_below[gi] : zeros_below[gi]);
      assign j[gi] = bus.load ?  load_value[gi] : (wrap ?  force_value[gi] : toggle[gi]);
      assign k[gi] = bus.load ? ~load_value[gi] : (wrap ? ~force_value[gi] : toggle[gi]);
      assign count_next[gi] = (j[gi] & ~count_reg[gi]) | (~k[gi] & count_reg[gi]);
    end
  endgenerate

  assign wrapped_next = bus.load ? 1'b0 : (wrap ? 1'b1 : wrapped_reg);

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign bus.count    = count_reg;
  assign bus.terminal = at_end;
  assign bus.carryout = wrap;
  assign bus.wrapped  = wrapped_reg;

endmodule
